// File: rtl/conv_pkg.sv
// Shared definitions for the convolution psum collector: default sizes,
// FSM state encoding and signed saturation limits.
package conv_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned PE_DIM_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Largest signed value representable in w bits
    function automatic longint sat_max(input int unsigned w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Most negative signed value representable in w bits
    function automatic longint sat_min(input int unsigned w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    localparam logic [DATA_W_DEF-1:0] SAT_MAX_DEF = DATA_W_DEF'(sat_max(DATA_W_DEF));
    localparam logic [DATA_W_DEF-1:0] SAT_MIN_DEF = DATA_W_DEF'(sat_min(DATA_W_DEF));

endpackage

// File: rtl/psum_col_adder.sv
// Vertical reduction of three PE psums into one output pixel: signed add
// with two guard bits, saturation to DATA_W, optional fused ReLU
// (enabled by defining PSUM_ACCUM_RELU_EN).
module psum_col_adder
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    input  logic signed [DATA_W-1:0] c_i,
    output logic signed [DATA_W-1:0] sum_o
);

    localparam int unsigned SUM_W = DATA_W + 2;
    localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'(sat_max(DATA_W));
    localparam logic signed [SUM_W-1:0] MIN_V = SUM_W'(sat_min(DATA_W));

    logic signed [SUM_W-1:0]  wide;
    logic signed [DATA_W-1:0] sat;

    // Sign-extended sum, clamp to DATA_W range, then optional ReLU
    always_comb begin
        wide = $signed({{2{a_i[DATA_W-1]}}, a_i})
             + $signed({{2{b_i[DATA_W-1]}}, b_i})
             + $signed({{2{c_i[DATA_W-1]}}, c_i});
        if (wide > MAX_V) begin
            sat = MAX_V[DATA_W-1:0];
        end else if (wide < MIN_V) begin
            sat = MIN_V[DATA_W-1:0];
        end else begin
            sat = wide[DATA_W-1:0];
        end
`ifdef PSUM_ACCUM_RELU_EN
        sum_o = sat[DATA_W-1] ? '0 : sat;
`else
        sum_o = sat;
`endif
    end

endmodule

// File: rtl/conv_psum_accum.sv
// Collects PE-array psum beats column by column into a 3x3 output tile,
// then streams the tile row-major over valid/ready. Optional fused ReLU
// is selected by the PSUM_ACCUM_RELU_EN macro (see psum_col_adder).
module conv_psum_accum
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned PE_DIM = PE_DIM_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            psum_valid,
    input  logic [PE_DIM*PE_DIM*DATA_W-1:0] psum_in,
    input  logic                            psum_last,
    output logic                            psum_ready,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               out_data,
    output logic [1:0]                      out_row,
    output logic [1:0]                      out_col,
    output logic                            out_last,
    output logic                            busy,
    output logic                            err
);

    localparam logic [1:0] LAST_IDX = 2'(PE_DIM - 1);

    state_e                   state_q;
    logic [1:0]               col_q;
    logic signed [DATA_W-1:0] tile_q [PE_DIM][PE_DIM];
    logic signed [DATA_W-1:0] col_sum [PE_DIM];

    logic                     psum_ready_q;
    logic                     out_valid_q;
    logic signed [DATA_W-1:0] out_data_q;
    logic [1:0]               out_row_q;
    logic [1:0]               out_col_q;
    logic                     out_last_q;
    logic                     busy_q;
    logic                     err_q;

    logic                     accept;
    logic                     tile_end;
    logic [1:0]               adv_row;
    logic [1:0]               adv_col;

    // One adder per output row j, summing PE[0..2][j]
    for (genvar j = 0; j < PE_DIM; j++) begin : g_row
        psum_col_adder #(.DATA_W(DATA_W)) u_add (
            .a_i   ($signed(psum_in[(0*PE_DIM + j)*DATA_W +: DATA_W])),
            .b_i   ($signed(psum_in[(1*PE_DIM + j)*DATA_W +: DATA_W])),
            .c_i   ($signed(psum_in[(2*PE_DIM + j)*DATA_W +: DATA_W])),
            .sum_o (col_sum[j])
        );
    end

    assign accept   = psum_valid && psum_ready_q;
    assign tile_end = (col_q == LAST_IDX) || psum_last;

    // Next row-major drain position; out_row_q/out_col_q double as the drain index
    always_comb begin
        adv_row = out_row_q;
        adv_col = out_col_q + 2'd1;
        if (out_col_q == LAST_IDX) begin
            adv_row = out_row_q + 2'd1;
            adv_col = 2'd0;
        end
    end

    // Tile FSM: accumulate columns, then drain one element per handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= 2'd0;
            psum_ready_q <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_row_q    <= 2'd0;
            out_col_q    <= 2'd0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            for (int unsigned r = 0; r < PE_DIM; r++) begin
                for (int unsigned c = 0; c < PE_DIM; c++) begin
                    tile_q[2'(r)][2'(c)] <= '0;
                end
            end
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        for (int unsigned j = 0; j < PE_DIM; j++) begin
                            tile_q[2'(j)][col_q] <= col_sum[j];
                        end
                        col_q  <= col_q + 2'd1;
                        busy_q <= 1'b1;
                        if (tile_end) begin
                            state_q      <= DRAIN;
                            psum_ready_q <= 1'b0;
                            if (psum_last && (col_q != LAST_IDX)) begin
                                err_q <= 1'b1;
                            end
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                DRAIN: begin
                    if (!out_valid_q) begin
                        // First element presented one cycle after the tile closes
                        out_valid_q <= 1'b1;
                        out_data_q  <= tile_q[0][0];
                        out_row_q   <= 2'd0;
                        out_col_q   <= 2'd0;
                        out_last_q  <= 1'b0;
                    end else if (out_ready) begin
                        if (out_last_q) begin
                            state_q      <= IDLE;
                            col_q        <= 2'd0;
                            psum_ready_q <= 1'b1;
                            busy_q       <= 1'b0;
                            out_valid_q  <= 1'b0;
                            out_data_q   <= '0;
                            out_row_q    <= 2'd0;
                            out_col_q    <= 2'd0;
                            out_last_q   <= 1'b0;
                            for (int unsigned r = 0; r < PE_DIM; r++) begin
                                for (int unsigned c = 0; c < PE_DIM; c++) begin
                                    tile_q[2'(r)][2'(c)] <= '0;
                                end
                            end
                        end else begin
                            out_row_q  <= adv_row;
                            out_col_q  <= adv_col;
                            out_data_q <= tile_q[adv_row][adv_col];
                            out_last_q <= (adv_row == LAST_IDX) && (adv_col == LAST_IDX);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign psum_ready = psum_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_conv_psum_accum.sv
// Bench for conv_psum_accum: tile-level reference model plus per-cycle compare.
module tb_conv_psum_accum;

    logic        clk;
    logic        rst;
    logic        psum_valid;
    logic [143:0] psum_in;
    logic        psum_last;
    logic        psum_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_row;
    logic [1:0]  out_col;
    logic        out_last;
    logic        busy;
    logic        err;

    conv_psum_accum dut (
        .clk        (clk),
        .rst        (rst),
        .psum_valid (psum_valid),
        .psum_in    (psum_in),
        .psum_last  (psum_last),
        .psum_ready (psum_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_last   (out_last),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int data;
        int row;
        int col;
        bit last;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    int   tile [3][3];
    int   model_col = 0;
    bit   model_err = 1'b0;
    int   cycle = 0;
    int   push_cycle = 0;
    int   last_hs_data = 0;
    time  last_hs_time = 0;
    time  last_acc_time = 0;
    bit   toggle_mode = 1'b0;
    int   pe [9];

    function automatic void check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endfunction

    // Reference: plain integer saturation to 16-bit signed, optional ReLU
    function automatic int model_sat(input int s);
        int r;
        r = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
`ifdef PSUM_ACCUM_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                tile[r][c] = 0;
        model_col = 0;
    endfunction

    // Present one beat, wait for acceptance, update the tile model
    task automatic send_beat(input int v[9], input bit last);
        int n;
        int s;
        exp_t e;
        @(negedge clk);
        for (int k = 0; k < 9; k++) psum_in[k*16 +: 16] = 16'(v[k]);
        psum_last  = last;
        psum_valid = 1'b1;
        n = 0;
        while (psum_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            check("beat_accept_timeout", 0, 1);
        end else begin
            last_acc_time = $time;
            @(posedge clk);
            #1;
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int i = 0; i < 3; i++) s += v[i*3 + j];
                tile[j][model_col] = model_sat(s);
            end
            if (model_col == 2 || last) begin
                if (last && model_col < 2) model_err = 1'b1;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++) begin
                        e.data = tile[r][c];
                        e.row  = r;
                        e.col  = c;
                        e.last = (r == 2 && c == 2);
                        exp_q.push_back(e);
                    end
                push_cycle = cycle;
                model_clear();
            end else begin
                model_col++;
            end
        end
    endtask

    // Hold psum_valid high until the tile has drained, then go quiet
    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("drain_timeout", 0, 1);
        psum_valid = 1'b0;
        psum_last  = 1'b0;
        @(negedge clk);
    endtask

    // Consumer back-pressure: always ready, or alternate every cycle
    always @(posedge clk) begin
        #2;
        if (toggle_mode) out_ready = ~out_ready;
        else             out_ready = 1'b1;
    end

    // Per-cycle compare against the model
    bit   stall_pend = 1'b0;
    int   st_data, st_row, st_col, st_last;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            cycle++;
            check("psum_ready", int'(psum_ready), int'(exp_q.size() == 0));
            check("busy", int'(busy), int'(exp_q.size() > 0 || model_col > 0));
            check("err", int'(err), int'(model_err));
            check("out_valid", int'(out_valid), int'(exp_q.size() > 0 && cycle > push_cycle + 1));
            if (stall_pend) begin
                check("stall_data", int'($signed(out_data)), st_data);
                check("stall_row", int'(out_row), st_row);
                check("stall_col", int'(out_col), st_col);
                check("stall_last", int'(out_last), st_last);
            end
            if (out_valid && !out_ready) begin
                stall_pend = 1'b1;
                st_data = int'($signed(out_data));
                st_row  = int'(out_row);
                st_col  = int'(out_col);
                st_last = int'(out_last);
            end else begin
                stall_pend = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", int'($signed(out_data)), e.data);
                    check("out_row", int'(out_row), e.row);
                    check("out_col", int'(out_col), e.col);
                    check("out_last", int'(out_last), int'(e.last));
                    last_hs_data = int'($signed(out_data));
                    if (out_last) last_hs_time = $time;
                end
            end
        end else begin
            stall_pend = 1'b0;
        end
    end

    initial begin
        int neg_exp;
        rst        = 1'b1;
        psum_valid = 1'b0;
        psum_last  = 1'b0;
        psum_in    = '0;
        out_ready  = 1'b1;
        model_clear();
        #1;
        check("rst_psum_ready", int'(psum_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_row", int'(out_row), 0);
        check("rst_out_col", int'(out_col), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Tile of all ones: every pixel is 3
        for (int k = 0; k < 9; k++) pe[k] = 1;
        send_beat(pe, 1'b0);
        send_beat(pe, 1'b0);
        send_beat(pe, 1'b1);
        @(negedge clk);
        check("t1_latency_valid_low", int'(out_valid), 0);
        @(negedge clk);
        check("t1_latency_valid_high", int'(out_valid), 1);
        check("t1_first_data", int'($signed(out_data)), 3);
        wait_drain();
        check("t1_pin_last", last_hs_data, 3);

        // Saturation, guard-bit width, no psum_last on column 2
        for (int i = 0; i < 3; i++) begin
            pe[i*3 + 0] = 28672;             // 0x7000
            pe[i*3 + 1] = i - 4;
        end
        pe[2] = 32767; pe[5] = 32767; pe[8] = -32768;
        send_beat(pe, 1'b0);
        for (int i = 0; i < 3; i++) begin
            pe[i*3 + 0] = -28672;            // 0x9000
            pe[i*3 + 1] = 1000 * (i + 1);
            pe[i*3 + 2] = -1;
        end
        send_beat(pe, 1'b0);
        for (int k = 0; k < 9; k++) pe[k] = k * 100 - 400;
        send_beat(pe, 1'b0);
        wait_drain();
        check("pin_sat_pos", model_sat(3 * 28672), 32767);
`ifdef PSUM_ACCUM_RELU_EN
        neg_exp = 0;
`else
        neg_exp = -32768;
`endif
        check("pin_sat_neg", model_sat(-3 * 28672), neg_exp);
        check("t2_pin_last", last_hs_data, 300);

        // Back-pressure toggling, psum_valid held through the drain
        toggle_mode = 1'b1;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 9; k++) pe[k] = k + c * 10;
            send_beat(pe, c == 2);
        end
        wait_drain();
        toggle_mode = 1'b0;
        @(negedge clk);

        // Early psum_last on column 0: err, remaining columns zero
        for (int k = 0; k < 9; k++) pe[k] = k + 1;
        send_beat(pe, 1'b1);
        @(negedge clk);
        check("t4_err_set", int'(err), 1);
        wait_drain();
        for (int k = 0; k < 9; k++) pe[k] = 2;
        send_beat(pe, 1'b0);
        send_beat(pe, 1'b0);
        send_beat(pe, 1'b0);
        wait_drain();
        check("t4_err_sticky", int'(err), 1);
        check("t4_pin_last", last_hs_data, 6);

        // Reset after beat 2 abandons the tile
        for (int k = 0; k < 9; k++) pe[k] = 7;
        send_beat(pe, 1'b0);
        send_beat(pe, 1'b0);
        psum_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_psum_ready", int'(psum_ready), 1);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_err", int'(err), 0);
        check("mid_rst_out_data", int'(out_data), 0);
        exp_q.delete();
        model_err = 1'b0;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 9; k++) pe[k] = 5;
        send_beat(pe, 1'b1);
        wait_drain();
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 9; k++) pe[k] = 3 * c - k;
            send_beat(pe, 1'b0);
        end
        wait_drain();

        // Back-to-back tiles with psum_valid continuously high
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                pe[i*3 + j] = i + j;
        send_beat(pe, 1'b0);
        send_beat(pe, 1'b0);
        send_beat(pe, 1'b1);
        for (int k = 0; k < 9; k++) pe[k] = 10;
        send_beat(pe, 1'b0);
        check("b2b_accept_time", int'((last_acc_time - last_hs_time) / 10), 1);
        check("b2b_tile1_pin", last_hs_data, 9);
        send_beat(pe, 1'b0);
        send_beat(pe, 1'b0);
        wait_drain();
        check("b2b_tile2_pin", last_hs_data, 30);

        // Single-beat tile after a full one: buffer must have been cleared
        for (int k = 0; k < 9; k++) pe[k] = -2;
        send_beat(pe, 1'b1);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
